// File: rtl/seven_seg_scan_ctrl_if.sv
// Display-side bundle of the 7-segment scan controller: value/shadow-load inputs from
// the producer logic and the registered segment/digit pins plus the frame strobe.
interface seven_seg_scan_ctrl_if #(
    parameter int unsigned N_DIGITS = 4
);
    logic [4*N_DIGITS-1:0] i_value;
    logic [N_DIGITS-1:0]   i_dp;
    logic [N_DIGITS-1:0]   i_digit_en;
    logic                  i_load;
    logic [7:0]            o_seg;
    logic [N_DIGITS-1:0]   o_dig;
    logic                  o_frame_done;

    modport master (
        output i_value, i_dp, i_digit_en, i_load,
        input  o_seg, o_dig, o_frame_done
    );

    modport slave (
        input  i_value, i_dp, i_digit_en, i_load,
        output o_seg, o_dig, o_frame_done
    );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-segment 7-segment display with a
// frame-synchronous shadow register so displayed values never tear mid-frame.
module seven_seg_scan_ctrl #(
    parameter int unsigned N_DIGITS       = 4,
    parameter int unsigned DIGIT_TICKS    = 4000,
    parameter int unsigned BLANK_TICKS    = 400,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
    input logic                  clk,
    input logic                  rst_n,
    seven_seg_scan_ctrl_if.slave bus
);

    localparam int unsigned MAX_TICKS = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
    localparam int unsigned TW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
    localparam int unsigned IW        = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned VW        = 4 * N_DIGITS;

    localparam logic [TW-1:0]       DIGIT_LAST = TW'(DIGIT_TICKS - 1);
    localparam logic [TW-1:0]       BLANK_LAST = TW'(BLANK_TICKS - 1);
    localparam logic [IW-1:0]       IDX_LAST   = IW'(N_DIGITS - 1);
    localparam logic [7:0]          SEG_OFF    = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [N_DIGITS-1:0] DIG_OFF    = DIG_ACTIVE_LOW ? {N_DIGITS{1'b1}}
                                                                : {N_DIGITS{1'b0}};

    typedef enum logic [0:0] {StBlank, StOn} state_e;

    state_e              state_q, state_d;
    logic [TW-1:0]       tick_q, tick_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                swap;

    logic [VW-1:0]       pend_value_q, pend_value_d;
    logic [N_DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic [N_DIGITS-1:0] pend_en_q, pend_en_d;
    logic [VW-1:0]       act_value_q, act_value_d;
    logic [N_DIGITS-1:0] act_dp_q, act_dp_d;
    logic [N_DIGITS-1:0] act_en_q, act_en_d;

    logic [7:0]          seg_q, seg_d;
    logic [N_DIGITS-1:0] dig_q, dig_d;
    logic                frame_done_q;

    logic [3:0]          nibble;
    logic [7:0]          seg_raw;
    logic [N_DIGITS-1:0] dig_sel;
    logic                lit;

    // Active-high {g,f,e,d,c,b,a}, bit0 = a.
    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            4'hF: s = 7'h71;
        endcase
        return s;
    endfunction

    // Scan sequencing: timing depends only on the tick/idx counters, never on inputs.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q + 1'b1;
        idx_d   = idx_q;
        swap    = 1'b0;
        unique case (state_q)
            StBlank: begin
                if (tick_q == BLANK_LAST) begin
                    state_d = StOn;
                    tick_d  = '0;
                end
            end
            StOn: begin
                if (tick_q == DIGIT_LAST) begin
                    state_d = StBlank;
                    tick_d  = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
                        swap  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
        endcase
    end

    // A load in the swap cycle feeds active directly through pend_*_d.
    always_comb begin
        pend_value_d = pend_value_q;
        pend_dp_d    = pend_dp_q;
        pend_en_d    = pend_en_q;
        if (bus.i_load) begin
            pend_value_d = bus.i_value;
            pend_dp_d    = bus.i_dp;
            pend_en_d    = bus.i_digit_en;
        end
        act_value_d = act_value_q;
        act_dp_d    = act_dp_q;
        act_en_d    = act_en_q;
        if (swap) begin
            act_value_d = pend_value_d;
            act_dp_d    = pend_dp_d;
            act_en_d    = pend_en_d;
        end
    end

    // Outputs are derived from next-state so pins change on the same edge as the FSM.
    always_comb begin
        nibble  = act_value_d[4*idx_d +: 4];
        seg_raw = {act_dp_d[idx_d], decode(nibble)};
        dig_sel = N_DIGITS'(1) << idx_d;
        lit     = (state_d == StOn) && act_en_d[idx_d];
        seg_d   = SEG_OFF;
        dig_d   = DIG_OFF;
        if (lit) begin
            seg_d = seg_raw ^ SEG_OFF;
            dig_d = dig_sel ^ DIG_OFF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StBlank;
            tick_q       <= '0;
            idx_q        <= '0;
            pend_value_q <= '0;
            pend_dp_q    <= '0;
            pend_en_q    <= '0;
            act_value_q  <= '0;
            act_dp_q     <= '0;
            act_en_q     <= '0;
            seg_q        <= SEG_OFF;
            dig_q        <= DIG_OFF;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            idx_q        <= idx_d;
            pend_value_q <= pend_value_d;
            pend_dp_q    <= pend_dp_d;
            pend_en_q    <= pend_en_d;
            act_value_q  <= act_value_d;
            act_dp_q     <= act_dp_d;
            act_en_q     <= act_en_d;
            seg_q        <= seg_d;
            dig_q        <= dig_d;
            frame_done_q <= swap;
        end
    end

    assign bus.o_seg        = seg_q;
    assign bus.o_dig        = dig_q;
    assign bus.o_frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench for seven_seg_scan_ctrl: stimulus queues per-cycle expected pin
// states, a negedge monitor pops and compares them against the DUT outputs.
module tb_seven_seg_scan_ctrl;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;

    typedef struct {
        int         cyc;
        int         fs;
        logic [3:0] dig;
        logic [7:0] seg;
        logic       fd;
    } exp_t;

    exp_t exp_q[$];

    seven_seg_scan_ctrl_if #(.N_DIGITS(4)) bus ();

    seven_seg_scan_ctrl #(
        .N_DIGITS      (4),
        .DIGIT_TICKS   (4),
        .BLANK_TICKS   (2),
        .SEG_ACTIVE_LOW(1'b1),
        .DIG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Posedges since the last reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Monitor: every sampled cycle with a queued expectation is compared.
    always @(negedge clk) begin
        if (rst_n) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL scan_missed cyc=%0d: entry for cyc %0d never sampled",
                         cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                if (bus.o_dig !== e.dig || bus.o_seg !== e.seg || bus.o_frame_done !== e.fd) begin
                    errors++;
                    $display("FAIL scan frame@%0d cyc=%0d: got dig=%b seg=%h fd=%b, want dig=%b seg=%h fd=%b",
                             e.fs, cyc, bus.o_dig, bus.o_seg, bus.o_frame_done, e.dig, e.seg, e.fd);
                end
            end
        end
    end

    // Expected pins for n cycles of a frame whose swap edge is cycle s.
    // segs = {digit3, digit2, digit1, digit0} in pin polarity.
    task automatic push_frame(input int s, input logic [31:0] segs, input logic [3:0] en,
                              input bit fd0, input int n);
        for (int o = 0; o < n; o++) begin
            exp_t       e;
            int         slot;
            logic [3:0] one;
            slot  = o / 6;
            one   = 4'b0001 << slot;
            e.cyc = s + o;
            e.fs  = s;
            e.fd  = fd0 && (o == 0);
            e.dig = 4'hF;
            e.seg = 8'hFF;
            if ((o % 6) >= 2 && en[slot]) begin
                e.dig = ~one;
                e.seg = segs[slot*8 +: 8];
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic check_now(input string name, input logic [3:0] dig, input logic [7:0] seg,
                             input logic fd);
        checks++;
        if (bus.o_dig !== dig || bus.o_seg !== seg || bus.o_frame_done !== fd) begin
            errors++;
            $display("FAIL %s: got dig=%b seg=%h fd=%b, want dig=%b seg=%h fd=%b",
                     name, bus.o_dig, bus.o_seg, bus.o_frame_done, dig, seg, fd);
        end
    endtask

    // Returns 1 time unit after the posedge that brings cyc to n.
    task automatic wait_cyc(input int n);
        int guard;
        guard = 0;
        while (cyc < n && guard < 1000) begin
            @(posedge clk);
            #1;
            guard++;
        end
    endtask

    // Called 1 unit after a posedge; i_load is high across exactly the next edge.
    task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] en);
        bus.i_value    = v;
        bus.i_dp       = dp;
        bus.i_digit_en = en;
        bus.i_load     = 1'b1;
        @(posedge clk);
        #1;
        bus.i_load     = 1'b0;
        bus.i_value    = 16'h5A5A;
        bus.i_dp       = 4'b1010;
        bus.i_digit_en = 4'b1111;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, queue=%0d", exp_q.size());
        $fatal(1, "timeout");
    end

    initial begin
        int guard;
        checks         = 0;
        errors         = 0;
        bus.i_value    = '0;
        bus.i_dp       = '0;
        bus.i_digit_en = '0;
        bus.i_load     = 1'b0;
        rst_n          = 1'b1;
        #1 rst_n = 1'b0;

        // Reset held while clocking.
        #1 check_now("reset_async", 4'hF, 8'hFF, 1'b0);
        repeat (3) @(posedge clk);
        #1 check_now("reset_hold_a", 4'hF, 8'hFF, 1'b0);
        @(negedge clk);
        check_now("reset_hold_b", 4'hF, 8'hFF, 1'b0);

        @(posedge clk);
        #2 rst_n = 1'b1;
        push_frame(0, 32'hFFFF_FFFF, 4'h0, 1'b0, 24);
        push_frame(24, 32'hFFFF_FFFF, 4'h0, 1'b1, 24);

        // 1234 loaded mid-frame shows from the next swap.
        wait_cyc(30);
        do_load(16'h1234, 4'h0, 4'hF);
        push_frame(48, 32'hF9A4_B099, 4'hF, 1'b1, 24);

        // Mid-frame reload: current frame keeps 1234, next one shows ABCD.
        wait_cyc(52);
        do_load(16'h1234, 4'h0, 4'hF);
        wait_cyc(60);
        do_load(16'hABCD, 4'h0, 4'hF);
        push_frame(72, 32'h8883_C6A1, 4'hF, 1'b1, 24);

        // Load coinciding with the swap edge at 96 bypasses pending.
        push_frame(96, 32'hC0C0_8EC0, 4'hF, 1'b1, 24);
        wait_cyc(95);
        do_load(16'h00F0, 4'h0, 4'hF);

        // Partial enables and a decimal point.
        wait_cyc(100);
        do_load(16'h8888, 4'b0001, 4'b0101);
        push_frame(120, 32'hFF80_FF00, 4'b0101, 1'b1, 24);
        push_frame(144, 32'hFF80_FF00, 4'b0101, 1'b1, 15);

        // Reset dropped during digit2's on-slot.
        wait_cyc(159);
        check_now("digit2_on_before_reset", 4'b1011, 8'h80, 1'b0);
        rst_n = 1'b0;
        #1 check_now("reset_mid_slot", 4'hF, 8'hFF, 1'b0);
        repeat (3) @(posedge clk);
        #1 check_now("reset_mid_slot_hold", 4'hF, 8'hFF, 1'b0);

        @(posedge clk);
        #2 rst_n = 1'b1;
        push_frame(0, 32'hFFFF_FFFF, 4'h0, 1'b0, 24);
        push_frame(24, 32'hFFFF_FFFF, 4'h0, 1'b1, 24);
        push_frame(48, 32'hFFFF_FFFF, 4'h0, 1'b1, 1);

        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
